seg7_scan_capture: RTL
======================

Name: seg7_scan_capture

Overview:
- Receiver side of the multiplexed 7-segment display interface: observes the active-low segment bus and the active-low digit-select lines.
- Recovers the 4-bit value shown on each digit position and stores it in a per-digit register.
- Reports per-digit validity, an end-of-frame pulse and illegal-pattern errors.
- Used as a self-check/loopback monitor alongside the display driver and in benches.

Parameters:
- DIGITS, 8: number of digit-select lines / digit positions (2..8).
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (1..255).
- IDX_W, 3: width of the digit index; must be ≥ clog2(DIGITS).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- iSeg  in  7  segment lines, active-low, bit0=a … bit6=g.
- iAn  in  DIGITS  digit selects, active-low; bit k selects position k.
- iClrErr  in  1  synchronous clear of the sticky error.
- oDigits  out  4*DIGITS  captured values; nibble k = position k.
- oValid  out  DIGITS  bit k set once position k has captured a legal value.
- oUpdate  out  1  one-cycle pulse when any nibble is written.
- oFrame  out  1  one-cycle pulse when every position has captured at least once since the previous pulse.
- oErr  out  1  sticky illegal-pattern flag.
- oErrIdx  out  IDX_W  position of the most recent illegal pattern.

Behaviour:
- Reset (async assert, sync release): oDigits=0, oValid=0, oUpdate=0, oFrame=0, oErr=0, oErrIdx=0. Stability counter=0, frame-seen mask=0, FSM=IDLE.
- Inputs are registered once before use; the sample pair {iAn,iSeg} is compared with the previous sample every cycle.
- Legal patterns (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Single-select: exactly one bit of iAn is 0. Selects that are all-high or have more than one bit low are not valid selections.
- IDLE: when the sample is single-select, load counter=1 and go to SETTLE. Otherwise stay in IDLE.
- SETTLE:
  - Sample changed, or no longer single-select → counter=1 (or IDLE if not single-select).
  - Sample unchanged → counter+1.
  - When counter reaches STABLE_CYCLES → capture, then go to HELD.
- Capture, legal pattern: write nibble k, set oValid[k], set frame mask bit k, pulse oUpdate next cycle.
- Capture, illegal pattern: nibble and oValid unchanged, oErr=1, oErrIdx=k, no oUpdate.
- HELD: no further capture while the sample is unchanged.
  - Sample changes to another single-select → SETTLE with counter=1.
  - Sample becomes not single-select → IDLE.
- STABLE_CYCLES=1 means capture on the first cycle a single-select sample is seen after a change. Total latency from input change to oUpdate is STABLE_CYCLES+2 cycles.
- Frame: when the mask becomes all-ones, pulse oFrame in the same cycle as that oUpdate and clear the mask. Recapturing an already-seen position does not pulse oFrame.
- Segment change with the same anode counts as a change: a new settle starts and the nibble is overwritten on capture.
- iClrErr with a simultaneous illegal capture: the error wins, oErr stays 1.
- Reset asserted mid-settle aborts the capture; no pulses are emitted.

Optional Feature:
- Macro SEG7_HEX_DECODE_EN.
- Defined: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 are also legal and decode to 4'hA..4'hF.
- Undefined: only 0-9 are legal; those six patterns set oErr like any other illegal pattern.

Test Plan:
- Reset, then iAn=8'hFE, iSeg=7'b0100100 held 6 cycles, STABLE_CYCLES=4 → oDigits[3:0]=2, oValid=8'h01, a single oUpdate pulse at cycle 6 after the change.
- Scan positions 0..7 with values 0..7, 5 cycles each → oFrame pulses once on the position-7 update, oDigits=32'h76543210. A second identical scan gives a second oFrame.
- Glitch: iAn=8'hFD held 3 cycles, then iSeg changed 1 cycle, then held 4 cycles → exactly one capture, with the final value.
- iAn=8'hFC (two low) with a valid iSeg held 20 cycles → no oUpdate, no oErr, outputs unchanged.
- iSeg=7'b1111111 on position 3, stable → oErr=1, oErrIdx=3, nibble 3 unchanged. iClrErr pulse → oErr=0.
- With SEG7_HEX_DECODE_EN: iSeg=7'b0001000 on position 0 → nibble=4'hA, no error. Without the macro: oErr=1.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// Multiplexed 7-segment bus monitor: recovers per-digit values from the scan.
// Define SEG7_HEX_DECODE_EN to also accept the A-F glyphs.
module seg7_scan_capture #(
   parameter int DIGITS        = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int IDX_W         = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          iSeg,
   input  logic [DIGITS-1:0]   iAn,
   input  logic                iClrErr,
   output logic [4*DIGITS-1:0] oDigits,
   output logic [DIGITS-1:0]   oValid,
   output logic                oUpdate,
   output logic                oFrame,
   output logic                oErr,
   output logic [IDX_W-1:0]    oErrIdx
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HELD
   } state_t;

   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   logic [DIGITS-1:0] an_q, an_p_q;
   logic [6:0]        seg_q, seg_p_q;

   logic [4*DIGITS-1:0] dig_q, dig_d;
   logic [DIGITS-1:0]   val_q, val_d;
   logic [DIGITS-1:0]   mask_q, mask_d;
   logic                upd_q, upd_d;
   logic                frm_q, frm_d;
   logic                err_q, err_d;
   logic [IDX_W-1:0]    eidx_q, eidx_d;

   logic             changed;
   logic             single;
   logic [IDX_W-1:0] sel_idx;
   logic [7:0]       nlow;
   logic             cap;
   logic             dec_ok;
   logic [3:0]       dec_val;

   // Idle bus (all lines high) is the reset sample: never a selection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q    <= '1;
         seg_q   <= '1;
         an_p_q  <= '1;
         seg_p_q <= '1;
      end else begin
         an_q    <= iAn;
         seg_q   <= iSeg;
         an_p_q  <= an_q;
         seg_p_q <= seg_q;
      end
   end

   assign changed = (an_q != an_p_q) || (seg_q != seg_p_q);

   always_comb begin
      nlow    = '0;
      sel_idx = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (!an_q[k]) begin
            nlow    = nlow + 8'd1;
            sel_idx = IDX_W'(k);
         end
      end
      single = (nlow == 8'd1);
   end

   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'h0;
      unique case (seg_q)
         7'b1000000: dec_val = 4'h0;
         7'b1111001: dec_val = 4'h1;
         7'b0100100: dec_val = 4'h2;
         7'b0110000: dec_val = 4'h3;
         7'b0011001: dec_val = 4'h4;
         7'b0010010: dec_val = 4'h5;
         7'b0000010: dec_val = 4'h6;
         7'b1111000: dec_val = 4'h7;
         7'b0000000: dec_val = 4'h8;
         7'b0010000: dec_val = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
         7'b0001000: dec_val = 4'hA;
         7'b0000011: dec_val = 4'hB;
         7'b1000110: dec_val = 4'hC;
         7'b0100001: dec_val = 4'hD;
         7'b0000110: dec_val = 4'hE;
         7'b0001110: dec_val = 4'hF;
`endif
         default:    dec_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap     = 1'b0;
      case (state_q)
         IDLE: begin
            if (single) begin
               cnt_d   = 8'd1;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (!single) begin
               state_d = IDLE;
            end else if (changed) begin
               cnt_d = 8'd1;
            end else if (cnt_q >= 8'(STABLE_CYCLES)) begin
               cap     = 1'b1;
               state_d = HELD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HELD: begin
            if (!single) begin
               state_d = IDLE;
            end else if (changed) begin
               cnt_d   = 8'd1;
               state_d = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A capture's error set takes priority over a same-cycle clear.
   always_comb begin
      dig_d  = dig_q;
      val_d  = val_q;
      mask_d = mask_q;
      upd_d  = 1'b0;
      frm_d  = 1'b0;
      err_d  = err_q;
      eidx_d = eidx_q;
      if (iClrErr) err_d = 1'b0;
      if (cap) begin
         if (dec_ok) begin
            dig_d[int'(sel_idx)*4 +: 4] = dec_val;
            val_d[sel_idx]  = 1'b1;
            mask_d[sel_idx] = 1'b1;
            upd_d           = 1'b1;
            if (&mask_d) begin
               frm_d  = 1'b1;
               mask_d = '0;
            end
         end else begin
            err_d  = 1'b1;
            eidx_d = sel_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dig_q   <= '0;
         val_q   <= '0;
         mask_q  <= '0;
         upd_q   <= 1'b0;
         frm_q   <= 1'b0;
         err_q   <= 1'b0;
         eidx_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         val_q   <= val_d;
         mask_q  <= mask_d;
         upd_q   <= upd_d;
         frm_q   <= frm_d;
         err_q   <= err_d;
         eidx_q  <= eidx_d;
      end
   end

   assign oDigits = dig_q;
   assign oValid  = val_q;
   assign oUpdate = upd_q;
   assign oFrame  = frm_q;
   assign oErr    = err_q;
   assign oErrIdx = eidx_q;

endmodule
